mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage that sits directly downstream of the execute stage and consumes its EX/MEM register outputs.
- Issues word loads and stores to the data memory/cache over a req/ready handshake, and raises a stall while an access is outstanding.
- Selects the write-back value and registers it into the MEM/WB pipeline register.
- Supplies a non-load forwarding value back to the execute stage.

Parameters:
- BIT_W, 32, datapath width.
- ADDR_W, 30, word-address width on the memory port; equals BIT_W-2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alu_result_in  in  BIT_W  byte address for loads/stores; ALU result otherwise
- mem_wdata_in  in  BIT_W  store data
- rd_in  in  5  destination register
- PC_plus_4_in  in  BIT_W  link value for jal/jalr
- memrd_in  in  1  load
- memwr_in  in  1  store
- mem2reg_in  in  1  write-back selects load data
- regwr_in  in  1  register write enable
- jump_in  in  1  write-back selects PC_plus_4_in
- stall_in  in  1  freeze request from other pipeline sources (I-side), excluding this block's own stall
- dmem_req  out  1  memory request
- dmem_wen  out  1  1 = write, 0 = read
- dmem_addr  out  ADDR_W  alu_result_in[BIT_W-1:2]
- dmem_wdata  out  BIT_W  mem_wdata_in
- dmem_rdata  in  BIT_W  read data, valid in the cycle dmem_ready=1
- dmem_ready  in  1  access complete, single-cycle pulse
- stall_out  out  1  this stage needs more cycles; OR-ed externally into the EX/ID/IF stall
- fwd_mem_dat  out  BIT_W  jump_in ? PC_plus_4_in : alu_result_in (combinational, non-load only)
- wb_data  out  BIT_W  registered write-back value
- wb_rd  out  5  registered rd
- wb_regwr  out  1  registered write enable

Behaviour:
- Clock and reset: one clock (clk); reset (rst_n) is asynchronous and active-low.
- Reset state: FSM=IDLE; wb_data=0, wb_rd=0, wb_regwr=0, rdata_buf=0; dmem_req=0, stall_out=0.
- access = memrd_in | memwr_in. If both are set, treat as a store.
- FSM states and transitions:
  - IDLE: dmem_req=access. If access & dmem_ready: go to DONE if stall_in, else stay in IDLE. If access & !dmem_ready: go to WAIT.
  - WAIT: dmem_req=1; inputs are held stable by the upstream stall. On dmem_ready: go to DONE if stall_in, else IDLE.
  - DONE: dmem_req=0. Access already completed, but the stage is frozen by stall_in; the access must not be re-issued. Go to IDLE when stall_in=0.
- dmem_wen, dmem_addr, dmem_wdata: driven combinationally from the current inputs whenever dmem_req=1. dmem_addr ignores address bits [1:0]; word access only.
- stall_out = access & !dmem_ready & (state==IDLE | state==WAIT). Zero-wait memory (ready in the request cycle) produces no stall.
- rdata_buf: loads dmem_rdata on every cycle with dmem_ready=1 and a pending read.
- load_data = (state==DONE) ? rdata_buf : dmem_rdata.
- wb_sel = jump_in ? PC_plus_4_in : (mem2reg_in ? load_data : alu_result_in).
- MEM/WB register update, in priority order:
  - stall_in=1: hold all wb_* values.
  - else stall_out=1: insert a bubble (wb_regwr<=0; wb_data and wb_rd hold).
  - else: wb_data<=wb_sel, wb_rd<=rd_in, wb_regwr<=regwr_in & (rd_in!=0).
- Latency:
  - Non-memory instruction: 1 cycle to wb_*.
  - Access with ready after N cycles: N+1 cycles; stall_out is high for N cycles.
- dmem_ready outside IDLE-with-access or WAIT is ignored.
- Asynchronous reset mid-access: dmem_req drops immediately and the FSM returns to IDLE; the memory side must abandon the transaction.

Decomposition:
- Shared package (riscv_pkg):
  - MEM FSM state encoding: IDLE=2'd0, WAIT=2'd1, DONE=2'd2.
  - Register-index width (5).
  - Word-offset constant (2).
- One sub-module: mem_wb_reg, the MEM/WB pipeline register with hold and bubble controls. The FSM and muxing stay in mem_stage.

Test Plan:
- ALU op: alu_result_in=0x1234, regwr=1, rd=5, no access -> next edge wb_data=0x1234, wb_rd=5, wb_regwr=1; stall_out never asserts.
- Load with 3-cycle latency: memrd=1, addr=0x100 -> dmem_req=1, dmem_addr=0x40, stall_out high 3 cycles; ready with rdata=0xDEADBEEF -> wb_data=0xDEADBEEF one edge later; wb_regwr=0 during the stall cycles.
- Store, zero-wait: memwr=1, addr=0x8, wdata=0xA5A5A5A5, ready same cycle -> dmem_wen=1, dmem_addr=0x2, one request cycle, no stall.
- Load completes while stall_in=1 for 2 more cycles -> FSM enters DONE, dmem_req=0 during hold; after release wb_data=buffered rdata; exactly one request handshake counted.
- jal: jump=1, PC_plus_4_in=0x44, rd=1 -> wb_data=0x44 and fwd_mem_dat=0x44. rd=0 with regwr=1 -> wb_regwr=0.
- Assert rst_n low while in WAIT -> dmem_req=0 and all wb_* =0 immediately; after release FSM=IDLE and a new load issues normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: MEM-stage FSM encoding and register-file geometry.
package riscv_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned WORD_OFS  = 2;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: hold freezes everything, bubble clears only the write enable.
module mem_wb_reg
  import riscv_pkg::*;
#(
  parameter int unsigned BIT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hold,
  input  logic                 bubble,
  input  logic [BIT_W-1:0]     data_in,
  input  logic [REG_IDX_W-1:0] rd_in,
  input  logic                 regwr_in,
  output logic [BIT_W-1:0]     wb_data,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic                 wb_regwr
);

  logic [BIT_W-1:0]     wb_data_q,  wb_data_d;
  logic [REG_IDX_W-1:0] wb_rd_q,    wb_rd_d;
  logic                 wb_regwr_q, wb_regwr_d;

  always_comb begin
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_regwr_d = wb_regwr_q;
    if (!hold) begin
      if (bubble) begin
        wb_regwr_d = 1'b0;
      end else begin
        wb_data_d  = data_in;
        wb_rd_d    = rd_in;
        wb_regwr_d = regwr_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_regwr_q <= 1'b0;
    end else begin
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_regwr_q <= wb_regwr_d;
    end
  end

  assign wb_data  = wb_data_q;
  assign wb_rd    = wb_rd_q;
  assign wb_regwr = wb_regwr_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: data-memory handshake, self-stall, write-back select
// and MEM/WB register.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int unsigned BIT_W  = 32,
  parameter int unsigned ADDR_W = BIT_W - 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BIT_W-1:0]     alu_result_in,
  input  logic [BIT_W-1:0]     mem_wdata_in,
  input  logic [REG_IDX_W-1:0] rd_in,
  input  logic [BIT_W-1:0]     PC_plus_4_in,
  input  logic                 memrd_in,
  input  logic                 memwr_in,
  input  logic                 mem2reg_in,
  input  logic                 regwr_in,
  input  logic                 jump_in,
  input  logic                 stall_in,
  output logic                 dmem_req,
  output logic                 dmem_wen,
  output logic [ADDR_W-1:0]    dmem_addr,
  output logic [BIT_W-1:0]     dmem_wdata,
  input  logic [BIT_W-1:0]     dmem_rdata,
  input  logic                 dmem_ready,
  output logic                 stall_out,
  output logic [BIT_W-1:0]     fwd_mem_dat,
  output logic [BIT_W-1:0]     wb_data,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic                 wb_regwr
);

  mem_state_e       state_q, state_d;
  logic [BIT_W-1:0] rdata_buf_q, rdata_buf_d;
  logic             access, is_store, active, rd_pending;
  logic [BIT_W-1:0] load_data, wb_sel;

  assign access   = memrd_in | memwr_in;
  assign is_store = memwr_in;
  assign active   = (state_q == MEM_IDLE) || (state_q == MEM_WAIT);

  // rst_n gates the request so an in-flight access is dropped the instant reset asserts
  assign dmem_req   = rst_n & access & active;
  assign stall_out  = rst_n & access & active & ~dmem_ready;
  assign dmem_wen   = dmem_req & is_store;
  assign dmem_addr  = alu_result_in[BIT_W-1:WORD_OFS];
  assign dmem_wdata = mem_wdata_in;
  assign rd_pending = dmem_req & ~is_store;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MEM_IDLE: if (access) state_d = dmem_ready ? (stall_in ? MEM_DONE : MEM_IDLE) : MEM_WAIT;
      MEM_WAIT: if (dmem_ready) state_d = stall_in ? MEM_DONE : MEM_IDLE;
      MEM_DONE: if (!stall_in) state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  always_comb begin
    rdata_buf_d = rdata_buf_q;
    if (rd_pending && dmem_ready) rdata_buf_d = dmem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MEM_IDLE;
      rdata_buf_q <= '0;
    end else begin
      state_q     <= state_d;
      rdata_buf_q <= rdata_buf_d;
    end
  end

  assign load_data   = (state_q == MEM_DONE) ? rdata_buf_q : dmem_rdata;
  assign wb_sel      = jump_in ? PC_plus_4_in : (mem2reg_in ? load_data : alu_result_in);
  assign fwd_mem_dat = jump_in ? PC_plus_4_in : alu_result_in;

  mem_wb_reg #(.BIT_W(BIT_W)) u_mem_wb (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (stall_in),
    .bubble   (stall_out),
    .data_in  (wb_sel),
    .rd_in    (rd_in),
    .regwr_in (regwr_in & (rd_in != '0)),
    .wb_data  (wb_data),
    .wb_rd    (wb_rd),
    .wb_regwr (wb_regwr)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver plays the memory with chosen latency and
// stall_in holds, monitor checks each retired instruction's write-back.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_result_in, mem_wdata_in, PC_plus_4_in, dmem_rdata;
  logic [4:0]  rd_in;
  logic        memrd_in, memwr_in, mem2reg_in, regwr_in, jump_in, stall_in, dmem_ready;
  logic        dmem_req, dmem_wen, stall_out, wb_regwr;
  logic [29:0] dmem_addr;
  logic [31:0] dmem_wdata, fwd_mem_dat, wb_data;
  logic [4:0]  wb_rd;

  mem_stage #(.BIT_W(32), .ADDR_W(30)) dut (
    .clk(clk), .rst_n(rst_n), .alu_result_in(alu_result_in), .mem_wdata_in(mem_wdata_in),
    .rd_in(rd_in), .PC_plus_4_in(PC_plus_4_in), .memrd_in(memrd_in), .memwr_in(memwr_in),
    .mem2reg_in(mem2reg_in), .regwr_in(regwr_in), .jump_in(jump_in), .stall_in(stall_in),
    .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .stall_out(stall_out),
    .fwd_mem_dat(fwd_mem_dat), .wb_data(wb_data), .wb_rd(wb_rd), .wb_regwr(wb_regwr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        regwr;
  } wb_t;

  wb_t  sb_q[$];
  event retire_ev;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // kind: 0 alu, 1 load, 2 store, 3 jal. n = memory latency, h = stall_in cycles from completion.
  task automatic run_instr(input int unsigned kind, input logic both, input logic [31:0] alu,
                           input logic [31:0] wdata, input logic [31:0] pc4, input logic [4:0] rd,
                           input logic regwr, input int unsigned n_in, input int unsigned h,
                           input logic [31:0] rdata);
    logic        acc;
    int unsigned n;
    wb_t         e;
    logic [31:0] fwd_exp;
    acc = (kind == 1) || (kind == 2);
    n   = acc ? n_in : 0;
    e.data  = (kind == 3) ? pc4 : ((kind == 1) ? rdata : alu);
    e.rd    = rd;
    e.regwr = regwr && (rd != 5'd0);
    sb_q.push_back(e);
    fwd_exp = (kind == 3) ? pc4 : alu;

    @(negedge clk);
    alu_result_in = alu;
    mem_wdata_in  = wdata;
    PC_plus_4_in  = pc4;
    rd_in         = rd;
    regwr_in      = regwr;
    memrd_in      = (kind == 1) || (kind == 2 && both);
    memwr_in      = (kind == 2);
    mem2reg_in    = (kind == 1);
    jump_in       = (kind == 3);
    for (int unsigned c = 0; c <= n + h; c++) begin
      if (c > 0) @(negedge clk);
      if (c < n)       dmem_ready = 1'b0;
      else if (c == n) dmem_ready = acc ? 1'b1 : 1'($urandom_range(0, 1));
      else             dmem_ready = 1'($urandom_range(0, 1));
      dmem_rdata = (c == n) ? rdata : $urandom;
      stall_in   = (c >= n) && (c < n + h);
      #1;
      chk("dmem_req",    {31'd0, dmem_req},  {31'd0, acc && c <= n});
      chk("stall_out",   {31'd0, stall_out}, {31'd0, acc && c < n});
      chk("fwd_mem_dat", fwd_mem_dat, fwd_exp);
      if (acc && c <= n) begin
        chk("dmem_addr",  {2'b00, dmem_addr}, {2'b00, alu[31:2]});
        chk("dmem_wen",   {31'd0, dmem_wen},  {31'd0, kind == 2});
        if (kind == 2) chk("dmem_wdata", dmem_wdata, wdata);
      end
      if (acc && c >= 1 && c <= n) chk("bubble_regwr", {31'd0, wb_regwr}, 32'd0);
      @(posedge clk);
    end
    -> retire_ev;
  endtask

  initial begin
    wb_t e;
    forever begin
      @(retire_ev);
      #1;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: actual empty required entry at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        chk("wb_data",  wb_data, e.data);
        chk("wb_rd",    {27'd0, wb_rd}, {27'd0, e.rd});
        chk("wb_regwr", {31'd0, wb_regwr}, {31'd0, e.regwr});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    alu_result_in = '0; mem_wdata_in = '0; PC_plus_4_in = '0; dmem_rdata = '0; rd_in = '0;
    memrd_in = 1'b0; memwr_in = 1'b0; mem2reg_in = 1'b0; regwr_in = 1'b0; jump_in = 1'b0;
    stall_in = 1'b0; dmem_ready = 1'b0;
    #3;
    memrd_in = 1'b1;
    #1;
    chk("rst_req",   {31'd0, dmem_req},  32'd0);
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    chk("rst_wb_data",  wb_data, 32'd0);
    chk("rst_wb_rd",    {27'd0, wb_rd}, 32'd0);
    chk("rst_wb_regwr", {31'd0, wb_regwr}, 32'd0);
    memrd_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_instr(0, 1'b0, 32'h1234, 32'h0, 32'h0, 5'd5, 1'b1, 0, 0, 32'h0);
    run_instr(1, 1'b0, 32'h100, 32'h0, 32'h0, 5'd3, 1'b1, 3, 0, 32'hDEADBEEF);
    run_instr(2, 1'b0, 32'h8, 32'hA5A5A5A5, 32'h0, 5'd0, 1'b0, 0, 0, 32'h0);
    run_instr(1, 1'b0, 32'h44C, 32'h0, 32'h0, 5'd9, 1'b1, 1, 3, 32'hCAFEF00D);
    run_instr(1, 1'b0, 32'h10, 32'h0, 32'h0, 5'd10, 1'b1, 0, 2, 32'h600DF00D);
    run_instr(3, 1'b0, 32'h999, 32'h0, 32'h44, 5'd1, 1'b1, 0, 0, 32'h0);
    run_instr(3, 1'b0, 32'h999, 32'h0, 32'h48, 5'd0, 1'b1, 0, 0, 32'h0);
    run_instr(2, 1'b1, 32'h20, 32'h13572468, 32'h0, 5'd4, 1'b1, 2, 0, 32'h0);
    run_instr(0, 1'b0, 32'h77, 32'h0, 32'h0, 5'd6, 1'b1, 0, 2, 32'h0);

    // reset while the load is waiting in WAIT
    @(negedge clk);
    alu_result_in = 32'h200; rd_in = 5'd7; regwr_in = 1'b1; memrd_in = 1'b1; memwr_in = 1'b0;
    mem2reg_in = 1'b1; jump_in = 1'b0; stall_in = 1'b0; dmem_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("wait_req",   {31'd0, dmem_req},  32'd1);
    chk("wait_stall", {31'd0, stall_out}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req",      {31'd0, dmem_req},  32'd0);
    chk("mid_rst_stall",    {31'd0, stall_out}, 32'd0);
    chk("mid_rst_wb_data",  wb_data, 32'd0);
    chk("mid_rst_wb_rd",    {27'd0, wb_rd}, 32'd0);
    chk("mid_rst_wb_regwr", {31'd0, wb_regwr}, 32'd0);
    @(negedge clk);
    memrd_in = 1'b0; mem2reg_in = 1'b0; regwr_in = 1'b0;
    rst_n = 1'b1;
    run_instr(1, 1'b0, 32'h300, 32'h0, 32'h0, 5'd8, 1'b1, 2, 0, 32'h0BADCAFE);

    for (int i = 0; i < 150; i++) begin
      run_instr($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0, $urandom);
    end

    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
